// File: rtl/u_line_buffer_3_pkg.sv
// Shared image-processing package: default geometry and the counter width helper.
package image_process_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/u_line_buffer_3_if.sv
// Pixel-stream interface of the line buffer: raster input side plus the aligned three-row output.
interface u_line_buffer_3_if #(
    parameter int PIX_W      = image_process_pkg::PIX_W_DEF,
    parameter int IMG_WIDTH  = image_process_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = image_process_pkg::IMG_HEIGHT_DEF
);
    localparam int CW = image_process_pkg::cnt_width(IMG_WIDTH);
    localparam int RW = image_process_pkg::cnt_width(IMG_HEIGHT);

    logic             sof;
    logic             ce;
    logic [PIX_W-1:0] pixel_in;
    logic [PIX_W-1:0] data_line_0;
    logic [PIX_W-1:0] data_line_1;
    logic [PIX_W-1:0] data_line_2;
    logic             out_ce;
    logic             window_valid;
    logic [CW-1:0]    col_cnt;
    logic [RW-1:0]    row_cnt;
    logic             frame_done;

    modport master (
        output sof, ce, pixel_in,
        input  data_line_0, data_line_1, data_line_2, out_ce, window_valid,
               col_cnt, row_cnt, frame_done
    );

    modport slave (
        input  sof, ce, pixel_in,
        output data_line_0, data_line_1, data_line_2, out_ce, window_valid,
               col_cnt, row_cnt, frame_done
    );

endinterface

// File: rtl/u_line_buffer_3_line_ram.sv
// u_line_ram: single-port line memory, combinational read of the addressed word, write on clock.
// A write in the same cycle as a read returns the old word, which the line shift depends on.
module u_line_ram
    import image_process_pkg::*;
#(
    parameter int WIDTH = PIX_W_DEF,
    parameter int DEPTH = IMG_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [cnt_width(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/u_line_buffer_3.sv
// Two-line delay buffer producing rows r-2, r-1, r per accepted pixel for the 3x3 window stage.
// Optional macro LINE_BUF_ZERO_FILL_EN blanks the rows above the top edge of the frame.
module u_line_buffer_3
    import image_process_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input logic              clk,
    input logic              rst,
    u_line_buffer_3_if.slave bus
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    next_col;
    logic [RW-1:0]    next_row;
    logic [CW-1:0]    pix_col;
    logic [RW-1:0]    pix_row;
    logic [PIX_W-1:0] line_a_q;
    logic [PIX_W-1:0] line_b_q;
    logic [PIX_W-1:0] top_pix;
    logic [PIX_W-1:0] mid_pix;

    // sof overrides whatever position the counters had reached.
    assign pix_col = bus.sof ? '0 : next_col;
    assign pix_row = bus.sof ? '0 : next_row;

    u_line_ram #(.WIDTH(PIX_W), .DEPTH(IMG_WIDTH)) line_a (
        .clk     (clk),
        .we      (bus.ce),
        .addr    (pix_col),
        .wr_data (bus.pixel_in),
        .rd_data (line_a_q)
    );

    u_line_ram #(.WIDTH(PIX_W), .DEPTH(IMG_WIDTH)) line_b (
        .clk     (clk),
        .we      (bus.ce),
        .addr    (pix_col),
        .wr_data (line_a_q),
        .rd_data (line_b_q)
    );

`ifdef LINE_BUF_ZERO_FILL_EN
    assign top_pix = (pix_row < RW'(2)) ? '0 : line_b_q;
    assign mid_pix = (pix_row < RW'(1)) ? '0 : line_a_q;
`else
    assign top_pix = line_b_q;
    assign mid_pix = line_a_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_col         <= '0;
            next_row         <= '0;
            bus.data_line_0  <= '0;
            bus.data_line_1  <= '0;
            bus.data_line_2  <= '0;
            bus.out_ce       <= 1'b0;
            bus.window_valid <= 1'b0;
            bus.col_cnt      <= '0;
            bus.row_cnt      <= '0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.out_ce       <= bus.ce;
            bus.window_valid <= 1'b0;
            bus.frame_done   <= 1'b0;
            if (bus.ce) begin
                bus.data_line_0  <= top_pix;
                bus.data_line_1  <= mid_pix;
                bus.data_line_2  <= bus.pixel_in;
                bus.col_cnt      <= pix_col;
                bus.row_cnt      <= pix_row;
                bus.window_valid <= (pix_row >= RW'(2)) && (pix_col >= CW'(2));
                bus.frame_done   <= (pix_row == ROW_LAST) && (pix_col == COL_LAST);
                if (pix_col == COL_LAST) begin
                    next_col <= '0;
                    next_row <= (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
                end else begin
                    next_col <= pix_col + CW'(1);
                    next_row <= pix_row;
                end
            end else if (bus.sof) begin
                next_col <= '0;
                next_row <= '0;
            end
        end
    end

endmodule
